// File: rtl/axis_pkt_arb_pkg.sv
// axis_pkt_arb_pkg: shared state encoding, source indices and default widths
package axis_pkt_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;
    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: one-stage AXI4-Stream pipeline register with data, last and tid
module axis_out_reg
    import axis_pkt_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  tid_i,
    input  logic                  tready_i,
    output logic                  out_ready_o,
    output logic                  tvalid_o,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tlast_o,
    output logic                  tid_o
);
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  tid_q, tid_d;

    assign out_ready_o = !valid_q || tready_i;

    // a load wins over an unload, so back-to-back beats keep valid high
    always_comb begin
        valid_d = load_i ? 1'b1 : (tready_i ? 1'b0 : valid_q);
        data_d  = load_i ? data_i : data_q;
        last_d  = load_i ? last_i : last_q;
        tid_d   = load_i ? tid_i : tid_q;
    end

    // output stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            tid_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            tid_q   <= tid_d;
        end
    end

    assign tvalid_o = valid_q;
    assign tdata_o  = data_q;
    assign tlast_o  = last_q;
    assign tid_o    = tid_q;
endmodule

// File: rtl/axis_pkt_arb.sv
// axis_pkt_arb: two-input packet-locked round-robin AXI4-Stream arbiter
module axis_pkt_arb
    import axis_pkt_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s0_AXIS_tdata,
    input  logic                  s0_AXIS_tvalid,
    input  logic                  s0_AXIS_tlast,
    output logic                  s0_AXIS_tready,
    input  logic [DATA_WIDTH-1:0] s1_AXIS_tdata,
    input  logic                  s1_AXIS_tvalid,
    input  logic                  s1_AXIS_tlast,
    output logic                  s1_AXIS_tready,
    output logic [DATA_WIDTH-1:0] m_AXIS_tdata,
    output logic                  m_AXIS_tvalid,
    output logic                  m_AXIS_tlast,
    output logic                  m_AXIS_tid,
    input  logic                  m_AXIS_tready,
    input  logic                  arb_en,
    output logic                  arb_idle,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1
);
    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                 out_ready, acc0, acc1, eop0, eop1;

    assign acc0 = (state_q == GRANT0) && s0_AXIS_tvalid && out_ready;
    assign acc1 = (state_q == GRANT1) && s1_AXIS_tvalid && out_ready;
    assign eop0 = acc0 && s0_AXIS_tlast;
    assign eop1 = acc1 && s1_AXIS_tlast;

    // grant FSM: arbitrate in IDLE, hold the grant until the packet's tlast
    always_comb begin
        state_d        = state_q;
        s0_AXIS_tready = 1'b0;
        s1_AXIS_tready = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_en && s0_AXIS_tvalid && s1_AXIS_tvalid)
                    state_d = (last_grant_q == SRC1) ? GRANT0 : GRANT1;
                else if (arb_en && s0_AXIS_tvalid)
                    state_d = GRANT0;
                else if (arb_en && s1_AXIS_tvalid)
                    state_d = GRANT1;
            end
            GRANT0: begin
                s0_AXIS_tready = out_ready;
                state_d        = eop0 ? IDLE : GRANT0;
            end
            GRANT1: begin
                s1_AXIS_tready = out_ready;
                state_d        = eop1 ? IDLE : GRANT1;
            end
            default: state_d = IDLE;
        endcase
    end

    // round-robin history and per-source packet counters (free-running wrap)
    always_comb begin
        last_grant_d = eop0 ? SRC0 : (eop1 ? SRC1 : last_grant_q);
        cnt0_d       = cnt0_q + CNT_WIDTH'(eop0);
        cnt1_d       = cnt1_q + CNT_WIDTH'(eop1);
    end

    // control state registers; last_grant resets to SRC1 so s0 wins first
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= SRC1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk        (clk),
        .rst_n      (resetn),
        .load_i     (acc0 || acc1),
        .data_i     (acc1 ? s1_AXIS_tdata : s0_AXIS_tdata),
        .last_i     (acc1 ? s1_AXIS_tlast : s0_AXIS_tlast),
        .tid_i      (acc1 ? SRC1 : SRC0),
        .tready_i   (m_AXIS_tready),
        .out_ready_o(out_ready),
        .tvalid_o   (m_AXIS_tvalid),
        .tdata_o    (m_AXIS_tdata),
        .tlast_o    (m_AXIS_tlast),
        .tid_o      (m_AXIS_tid)
    );

    assign arb_idle = (state_q == IDLE) && !m_AXIS_tvalid;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
endmodule

// File: tb/tb_axis_pkt_arb.sv
// tb_axis_pkt_arb: directed scoreboard bench for the packet arbiter
module tb_axis_pkt_arb;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk;
    logic          resetn;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic          s0_tvalid, s0_tlast, s0_tready;
    logic          s1_tvalid, s1_tlast, s1_tready;
    logic          m_tvalid, m_tlast, m_tid, m_tready;
    logic          arb_en, arb_idle;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    logic [33:0]   sb[$];
    int            n_tests, n_fail;
    logic          held;
    logic [34:0]   hold_v;
    logic          bp;

    axis_pkt_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s0_AXIS_tdata (s0_tdata),
        .s0_AXIS_tvalid(s0_tvalid),
        .s0_AXIS_tlast (s0_tlast),
        .s0_AXIS_tready(s0_tready),
        .s1_AXIS_tdata (s1_tdata),
        .s1_AXIS_tvalid(s1_tvalid),
        .s1_AXIS_tlast (s1_tlast),
        .s1_AXIS_tready(s1_tready),
        .m_AXIS_tdata  (m_tdata),
        .m_AXIS_tvalid (m_tvalid),
        .m_AXIS_tlast  (m_tlast),
        .m_AXIS_tid    (m_tid),
        .m_AXIS_tready (m_tready),
        .arb_en        (arb_en),
        .arb_idle      (arb_idle),
        .pkt_cnt0      (pkt_cnt0),
        .pkt_cnt1      (pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic src, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            sb.push_back({src, (i == n - 1) ? 1'b1 : 1'b0, base + 32'(i)});
    endtask

    // AXIS source: holds each beat until it sees tready, aborts on reset
    task automatic send(input logic src, input logic [31:0] base, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            if (src) begin
                s1_tdata = base + 32'(i); s1_tvalid = 1'b1; s1_tlast = (i == n - 1);
            end else begin
                s0_tdata = base + 32'(i); s0_tvalid = 1'b1; s0_tlast = (i == n - 1);
            end
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(src ? s1_tready : s0_tready) && resetn && t < 300);
            if (!resetn || t >= 300) begin
                if (t >= 300) check("src_timeout", 64'(t), 64'(0));
                if (src) s1_tvalid = 1'b0; else s0_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (src) begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
        else begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; held = 1'b0; hold_v = '0; bp = 1'b0;
        s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
        s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
        m_tready = 1'b1; arb_en = 1'b1; resetn = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!resetn) held = 1'b0;
                else begin
                    if (held) check("stall_hold", {m_tvalid, m_tid, m_tlast, m_tdata}, hold_v);
                    if (m_tvalid && m_tready) begin
                        if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'(1));
                        else check("beat", {m_tid, m_tlast, m_tdata}, sb.pop_front());
                        held = 1'b0;
                    end else begin
                        held   = m_tvalid;
                        hold_v = {m_tvalid, m_tid, m_tlast, m_tdata};
                    end
                end
            end
        join_none

        #2 resetn = 1'b0;
        #1;
        check("rst_s0_tready", s0_tready, 0);
        check("rst_s1_tready", s1_tready, 0);
        check("rst_idle", arb_idle, 1);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_cnt0", pkt_cnt0, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // single source, 4 beats
        push(0, 32'h11, 4);
        send(0, 32'h11, 4);
        check("s1_last_valid", m_tvalid, 1);
        check("s1_last_data", {m_tid, m_tlast, m_tdata}, {2'b01, 32'h14});
        check("s1_busy", arb_idle, 0);
        check("s1_cnt0", pkt_cnt0, 1);
        @(posedge clk); #1;
        check("s1_idle_after", arb_idle, 1);

        // backpressure on a 6-beat s1 packet
        push(1, 32'h60, 6);
        bp = 1'b1;
        fork
            begin send(1, 32'h60, 6); bp = 1'b0; end
            while (bp) begin @(posedge clk); #1 m_tready = ~m_tready; end
        join
        m_tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("bp_cnt1", pkt_cnt1, 1);

        // contention: s0 must win first, then strict alternation
        push(0, 32'h100, 3); push(1, 32'h200, 3);
        push(0, 32'h110, 3); push(1, 32'h210, 3);
        fork
            begin send(0, 32'h100, 3); send(0, 32'h110, 3); end
            begin send(1, 32'h200, 3); send(1, 32'h210, 3); end
        join
        repeat (2) @(posedge clk); #1;
        check("cont_cnt0", pkt_cnt0, 3);
        check("cont_cnt_eq", pkt_cnt0, pkt_cnt1);

        // drain: arb_en dropped after beat 2 of a 5-beat packet
        push(0, 32'h51, 5);
        fork
            send(0, 32'h51, 5);
            begin repeat (3) @(posedge clk); #1 arb_en = 1'b0; end
        join
        check("drain_busy", arb_idle, 0);
        s0_tvalid = 1'b1; s0_tdata = 32'hDEAD; s0_tlast = 1'b1;
        s1_tvalid = 1'b1; s1_tdata = 32'hBEEF; s1_tlast = 1'b1;
        @(posedge clk); #1;
        check("drain_idle", arb_idle, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_no_grant", {s0_tready, s1_tready, m_tvalid}, 0);
        end
        @(posedge clk); #1;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
        arb_en = 1'b1;
        check("drain_cnt0", pkt_cnt0, 4);

        // reset in the middle of an s1 packet
        push(1, 32'h300, 6);
        fork
            send(1, 32'h300, 6);
            begin
                repeat (4) @(posedge clk);
                #3 resetn = 1'b0;
                #1;
                check("mid_rst_tvalid", m_tvalid, 0);
                check("mid_rst_tdata", m_tdata, 0);
                check("mid_rst_idle", arb_idle, 1);
                check("mid_rst_cnt", {pkt_cnt0, pkt_cnt1}, 0);
                check("mid_rst_tready", {s0_tready, s1_tready}, 0);
                sb.delete();
            end
        join
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        push(0, 32'hA0, 1); push(1, 32'hB0, 1);
        fork
            send(0, 32'hA0, 1);
            send(1, 32'hB0, 1);
        join
        repeat (2) @(posedge clk); #1;
        check("post_rst_cnt", {pkt_cnt0, pkt_cnt1}, {8'd1, 8'd1});

        // counter wrap with single-beat s0 packets
        for (int i = 0; i < 254; i++) begin
            push(0, 32'h1000 + 32'(i), 1);
            send(0, 32'h1000 + 32'(i), 1);
        end
        @(posedge clk); #1;
        check("wrap_max", pkt_cnt0, 8'hFF);
        push(0, 32'h2000, 1);
        send(0, 32'h2000, 1);
        @(posedge clk); #1;
        check("wrap_zero", pkt_cnt0, 0);
        repeat (2) @(posedge clk); #1;
        check("sb_drained", 64'(sb.size()), 0);
        check("final_idle", arb_idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_pkt_arb.md
# axis_pkt_arb

Two-input, packet-granular round-robin arbiter that shares one 32-bit AXI4-Stream datapath (the 32→24-bit mask stage ahead of the video sink) between two producers. Grants are locked for a whole packet (tlast-terminated), so packets never interleave. An enable/idle pair lets the DFX controller stop new grants and wait for the datapath to drain before decoupling the reconfigurable partition.

## Interface
- DATA_WIDTH, 32, tdata width of both inputs and the output
- CNT_WIDTH, 16, width of the per-source packet counters
- clk  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- s0_AXIS_tdata / s1_AXIS_tdata  in  DATA_WIDTH  input stream data
- s0_AXIS_tvalid / s1_AXIS_tvalid  in  1  input valid
- s0_AXIS_tlast / s1_AXIS_tlast  in  1  end-of-packet marker
- s0_AXIS_tready / s1_AXIS_tready  out  1  input ready
- m_AXIS_tdata  out  DATA_WIDTH  registered output data, to the mask stage
- m_AXIS_tvalid  out  1  registered output valid
- m_AXIS_tlast  out  1  registered output last
- m_AXIS_tid  out  1  source index of the current output beat
- m_AXIS_tready  in  1  downstream ready
- arb_en  in  1  1 = new grants allowed
- arb_idle  out  1  FSM in IDLE and output register empty
- pkt_cnt0 / pkt_cnt1  out  CNT_WIDTH  packets completed per source

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE: both s*_AXIS_tready = 0. If arb_en = 1 and exactly one source has tvalid = 1, go to that source's GRANT state. If both are valid, grant the source not served last (last_grant register; reset value 1, so s0 wins the first contention). If arb_en = 0 or no valid, stay.
- GRANTn: sn_AXIS_tready = out_ready, where out_ready = !m_AXIS_tvalid || m_AXIS_tready. The other input's tready = 0. An accepted beat (sn_tvalid && sn_tready) loads the output register with data, last and tid = n.
- An accepted beat with tlast = 1 sets last_grant = n, increments pkt_cntn (wraps modulo 2^CNT_WIDTH), and moves to IDLE.
- arb_en deasserted during GRANTn does not abort: the packet completes to tlast, and no new grant follows.
- Output register: m_AXIS_tvalid clears on m_AXIS_tready when no new beat is loaded; load and unload in the same cycle keep tvalid = 1. Data is stable while tvalid && !tready.
- arb_idle = (state == IDLE) && !m_AXIS_tvalid. This is combinational from registered state.

## Timing
- Reset (resetn = 0, asynchronous): state = IDLE, last_grant = 1, m_AXIS_tvalid/tlast/tid = 0, m_AXIS_tdata = 0, pkt_cnt0/1 = 0. Both s*_tready = 0 and arb_idle = 1.
- Reset asserted mid-packet: the partial packet is dropped and nothing is replayed. The upstream sources are reset by the same resetn.
- Latency: input beat accepted at edge k appears on m_AXIS_* after edge k (1 cycle).
- Throughput: 1 beat/cycle within a packet while downstream is ready. Exactly one idle arbitration cycle follows each packet's tlast acceptance, so an N-beat packet occupies N+1 cycles.
- Backpressure: m_AXIS_tready = 0 with tvalid = 1 forces the granted tready to 0 in the same cycle (combinational path m_AXIS_tready → s*_tready).
- A single-beat packet (tvalid and tlast on the first beat) is granted, accepted in one cycle, and returns to IDLE.
- Counter wrap: 0xFFFF + 1 = 0x0000, with no saturation and no flag.

## Structure
- Package axis_pkt_arb_pkg holds:
  - state enum (IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2)
  - source index constants SRC0 = 1'b0, SRC1 = 1'b1
  - default widths
- Sub-module axis_out_reg: a one-stage AXIS pipeline register (data, last, tid, valid; exports out_ready). It is reusable across the other stream blocks.
- Top level contains the FSM, grant muxing, last_grant and the counters.

## Test plan
- Single source: s0 sends 4 beats 0x11..0x14 with tlast on 0x14, m_tready = 1 → output appears 1 cycle later with tid = 0 and tlast on beat 4, pkt_cnt0 = 1, then one IDLE cycle.
- Contention: both sources present 3-beat packets continuously → output order s0, s1, s0, s1 with no interleaving inside a packet; cnt0 = cnt1 after an even number of packets.
- Backpressure: toggle m_tready 1/0 every cycle during a 6-beat s1 packet → all 6 beats delivered in order, no duplicates, and tdata held stable while stalled.
- Drain: deassert arb_en at beat 2 of a 5-beat packet → the packet completes, no new grant occurs with both sources valid, and arb_idle rises the cycle after the last output beat is taken.
- Reset mid-packet: assert resetn = 0 at beat 3 → all outputs return to reset values immediately, arb_idle = 1, counters = 0, and s0 wins the first contention after release.
- Wrap: preload traffic of 65536 single-beat s0 packets → pkt_cnt0 returns to 0x0000.
